// File: rtl/mem_port_arbiter.sv
// Shares one RAM data port: CPU strict priority, VGA/IO round-robin; ARB_STARVE_GUARD_EN adds a VGA/IO starvation override.
// Grant and RAM strobes one cycle after request sampling, read data two cycles after grant; requesters hold req until gnt.
module mem_port_arbiter #(
   parameter int WIDTH        = 16,
   parameter int ADDR_W       = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [WIDTH-1:0]  cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_adr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_adr,
   input  logic [WIDTH-1:0]  io_wdata,
   output logic              io_gnt,
   output logic              io_rvalid,
   output logic [WIDTH-1:0]  rdata,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [WIDTH-1:0]  mem_rdata
);

   logic       w_sel_cpu;
   logic       w_sel_vga;
   logic       w_sel_io;
   logic       w_rr_vga;
   logic       r_ptr_io;
   logic [2:0] r_tag_iss;
   logic [2:0] r_tag_ram;

   // Round-robin winner among VGA/IO when the CPU does not take the slot.
   assign w_rr_vga = vga_req && (!io_req || !r_ptr_io);

`ifdef ARB_STARVE_GUARD_EN
   localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] r_vga_wait;
   logic [CNT_W-1:0] r_io_wait;
   logic             w_vga_starved;
   logic             w_io_starved;

   assign w_vga_starved = vga_req && (r_vga_wait == LIMIT);
   assign w_io_starved  = io_req  && (r_io_wait  == LIMIT);

   always_comb begin
      w_sel_cpu = 1'b0;
      w_sel_vga = 1'b0;
      w_sel_io  = 1'b0;
      if (w_vga_starved && w_io_starved) begin
         w_sel_vga = !r_ptr_io;
         w_sel_io  = r_ptr_io;
      end else if (w_vga_starved) begin
         w_sel_vga = 1'b1;
      end else if (w_io_starved) begin
         w_sel_io = 1'b1;
      end else if (cpu_req) begin
         w_sel_cpu = 1'b1;
      end else if (vga_req || io_req) begin
         w_sel_vga = w_rr_vga;
         w_sel_io  = !w_rr_vga;
      end
   end

   // Any VGA/IO grant hands fairness back to the round-robin, so both waits restart.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vga_wait <= '0;
         r_io_wait  <= '0;
      end else if (w_sel_vga || w_sel_io) begin
         r_vga_wait <= '0;
         r_io_wait  <= '0;
      end else begin
         r_vga_wait <= !vga_req ? '0 : (r_vga_wait == LIMIT) ? LIMIT : r_vga_wait + CNT_W'(1);
         r_io_wait  <= !io_req  ? '0 : (r_io_wait  == LIMIT) ? LIMIT : r_io_wait  + CNT_W'(1);
      end
   end
`else
   always_comb begin
      w_sel_cpu = 1'b0;
      w_sel_vga = 1'b0;
      w_sel_io  = 1'b0;
      if (cpu_req) begin
         w_sel_cpu = 1'b1;
      end else if (vga_req || io_req) begin
         w_sel_vga = w_rr_vga;
         w_sel_io  = !w_rr_vga;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_gnt    <= 1'b0;
         vga_gnt    <= 1'b0;
         io_gnt     <= 1'b0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         mem_adr    <= '0;
         mem_wdata  <= '0;
         r_ptr_io   <= 1'b0;
         r_tag_iss  <= '0;
         r_tag_ram  <= '0;
         cpu_rvalid <= 1'b0;
         vga_rvalid <= 1'b0;
         io_rvalid  <= 1'b0;
         rdata      <= '0;
      end else begin
         cpu_gnt <= w_sel_cpu;
         vga_gnt <= w_sel_vga;
         io_gnt  <= w_sel_io;
         mem_we  <= (w_sel_cpu && cpu_we) || (w_sel_io && io_we);
         mem_re  <= (w_sel_cpu && !cpu_we) || w_sel_vga || (w_sel_io && !io_we);
         if (w_sel_cpu) begin
            mem_adr   <= cpu_adr;
            mem_wdata <= cpu_wdata;
         end else if (w_sel_vga) begin
            mem_adr <= vga_adr;
         end else if (w_sel_io) begin
            mem_adr   <= io_adr;
            mem_wdata <= io_wdata;
         end
         if (w_sel_vga || w_sel_io) begin
            r_ptr_io <= !r_ptr_io;
         end
         // Read-owner tags {io, vga, cpu}: issue stage, then RAM stage, then return.
         r_tag_iss <= {w_sel_io && !io_we, w_sel_vga, w_sel_cpu && !cpu_we};
         r_tag_ram <= r_tag_iss;
         cpu_rvalid <= r_tag_ram[0];
         vga_rvalid <= r_tag_ram[1];
         io_rvalid  <= r_tag_ram[2];
         if (|r_tag_ram) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed traffic, a per-cycle reference model of the arbitration rules, and a synchronous RAM.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_adr = '0, cpu_wdata = '0;
   logic        vga_req = 1'b0;
   logic [15:0] vga_adr = '0;
   logic        io_req = 1'b0, io_we = 1'b0;
   logic [15:0] io_adr = '0, io_wdata = '0;
   logic        cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, io_gnt, io_rvalid;
   logic [15:0] rdata, mem_adr, mem_wdata;
   logic        mem_we, mem_re;
   logic [15:0] mem_rdata = '0;

   int n_vec = 0;
   int n_err = 0;

   mem_port_arbiter #(.WIDTH(16), .ADDR_W(16), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .vga_req(vga_req), .vga_adr(vga_adr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
      .io_req(io_req), .io_we(io_we), .io_adr(io_adr), .io_wdata(io_wdata),
      .io_gnt(io_gnt), .io_rvalid(io_rvalid),
      .rdata(rdata), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input int i);
      logic [7:0] b;
      b = i[7:0];
      return (b == 8'h20) ? 16'h1234 : {b, ~b};
   endfunction

   // Synchronous RAM behind the port: write and read capture on the edge after the strobe.
   logic [15:0] ram [0:255];
   bit          ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
         ram_loaded <= 1'b1;
      end else begin
         if (mem_we) ram[mem_adr[7:0]] <= mem_wdata;
         if (mem_re) mem_rdata <= ram[mem_adr[7:0]];
      end
   end

   // Reference model: owner codes 1=cpu 2=vga 3=io; read data is the memory image at grant time.
   typedef struct {
      int          due;
      int          own;
      logic [15:0] dat;
   } ret_t;

   ret_t        pq[$];
   logic [15:0] mdl_mem [0:255];
   bit          m_loaded = 1'b0;
   int          cyc = 0, ptr = 0, vw = 0, iw = 0;
   logic [2:0]  e_gnt = '0, e_rv = '0;
   logic        e_we = 1'b0, e_re = 1'b0;
   logic [15:0] e_adr = '0, e_wd = '0, e_rd = '0;

   always @(posedge clk or negedge rst) begin
      int          win;
      bit          wr, vs, is;
      logic [15:0] a, d;
      ret_t        r;
      if (!rst) begin
         if (!m_loaded) begin
            for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
            m_loaded = 1'b1;
         end
         pq.delete();
         ptr = 0; vw = 0; iw = 0;
         e_gnt = '0; e_rv = '0; e_we = 1'b0; e_re = 1'b0;
         e_adr = '0; e_wd = '0; e_rd = '0;
      end else begin
         e_rv = '0;
         if (pq.size() > 0 && pq[0].due == cyc) begin
            r = pq.pop_front();
            e_rv[r.own-1] = 1'b1;
            e_rd = r.dat;
         end
         win = 0;
         if (cpu_req) win = 1;
         else if (vga_req && io_req) win = (ptr == 0) ? 2 : 3;
         else if (vga_req) win = 2;
         else if (io_req) win = 3;
`ifdef ARB_STARVE_GUARD_EN
         vs = vga_req && (vw == 8);
         is = io_req && (iw == 8);
         if (vs && is) win = (ptr == 0) ? 2 : 3;
         else if (vs) win = 2;
         else if (is) win = 3;
         if (win >= 2) begin
            vw = 0; iw = 0;
         end else begin
            vw = vga_req ? ((vw < 8) ? vw + 1 : 8) : 0;
            iw = io_req  ? ((iw < 8) ? iw + 1 : 8) : 0;
         end
`else
         vs = 1'b0; is = 1'b0;
`endif
         e_gnt = '0; e_we = 1'b0; e_re = 1'b0;
         if (win != 0) begin
            e_gnt[win-1] = 1'b1;
            case (win)
               1:       begin a = cpu_adr; wr = cpu_we; d = cpu_wdata; end
               2:       begin a = vga_adr; wr = 1'b0;   d = e_wd;      end
               default: begin a = io_adr;  wr = io_we;  d = io_wdata;  end
            endcase
            e_adr = a;
            e_wd  = d;
            if (wr) begin
               e_we = 1'b1;
               mdl_mem[a[7:0]] = d;
            end else begin
               e_re = 1'b1;
               pq.push_back('{due: cyc + 2, own: win, dat: mdl_mem[a[7:0]]});
            end
            if (win >= 2) ptr = 1 - ptr;
         end
         cyc++;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(posedge clk) begin
      #1;
      chk("model", {io_gnt, vga_gnt, cpu_gnt, io_rvalid, vga_rvalid, cpu_rvalid,
                    mem_we, mem_re, mem_adr, mem_wdata, rdata},
                   {e_gnt, e_rv, e_we, e_re, e_adr, e_wd, e_rd});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      bit rv_seen;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      repeat (10) begin
         @(posedge clk); #1;
         chk("idle", {cpu_gnt, vga_gnt, io_gnt, cpu_rvalid, vga_rvalid, io_rvalid,
                      mem_we, mem_re, mem_adr, mem_wdata, rdata}, 64'd0);
      end

      // CPU read of preloaded word
      @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0020;
      @(posedge clk); #1;
      chk("cpu_rd_issue", {cpu_gnt, vga_gnt, io_gnt, mem_re, mem_we, mem_adr}, {5'b10010, 16'h0020});
      @(negedge clk); cpu_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("cpu_rd_return", {cpu_rvalid, vga_rvalid, io_rvalid, rdata}, {3'b100, 16'h1234});

      // Round-robin VGA / IO
      @(negedge clk); vga_req = 1'b1; io_req = 1'b1; vga_adr = 16'h0030; io_adr = 16'h0031; io_we = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (k < 4) chk($sformatf("rr_gnt%0d", k), {vga_gnt, io_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
         if (k >= 2) chk($sformatf("rr_ret%0d", k), {vga_rvalid, io_rvalid, rdata},
                         (k % 2 == 0) ? {2'b10, 16'h30CF} : {2'b01, 16'h31CE});
         if (k == 3) begin
            @(negedge clk); vga_req = 1'b0; io_req = 1'b0;
         end
      end

      // All three requesting
      @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0021; vga_req = 1'b1; io_req = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
`ifdef ARB_STARVE_GUARD_EN
         chk($sformatf("prio%0d", k), {cpu_gnt, vga_gnt, io_gnt},
             (k == 9) ? 3'b010 : (k == 18) ? 3'b001 : 3'b100);
`else
         chk($sformatf("prio%0d", k), {cpu_gnt, vga_gnt, io_gnt}, 3'b100);
`endif
      end
      @(negedge clk); cpu_req = 1'b0; vga_req = 1'b0; io_req = 1'b0;
      repeat (3) @(posedge clk);

      // IO write followed by CPU read of the same word
      @(negedge clk); io_req = 1'b1; io_we = 1'b1; io_adr = 16'h0025; io_wdata = 16'h0001;
      @(posedge clk); #1;
      chk("wr_issue", {io_gnt, mem_we, mem_re, mem_adr, mem_wdata}, {3'b110, 16'h0025, 16'h0001});
      @(negedge clk); io_req = 1'b0; io_we = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0025;
      @(posedge clk); #1;
      chk("rd_issue", {cpu_gnt, mem_we, mem_re, mem_adr}, {3'b101, 16'h0025});
      @(negedge clk); cpu_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("wr_rd_data", {cpu_rvalid, rdata}, {1'b1, 16'h0001});

      // Reset one cycle after a VGA grant; pointer is left at IO beforehand
      @(negedge clk); io_req = 1'b1; io_we = 1'b1; io_adr = 16'h0026; io_wdata = 16'hBEEF;
      @(negedge clk); io_req = 1'b0; io_we = 1'b0; vga_req = 1'b1; vga_adr = 16'h0031;
      got = 1'b0;
      for (int k = 0; k < 5 && !got; k++) begin
         @(posedge clk); #1;
         got = vga_gnt;
      end
      chk("rst_vga_gnt", {7'd0, got}, 64'd1);
      @(negedge clk); vga_req = 1'b0;
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      rv_seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         rv_seen |= vga_rvalid;
      end
      chk("rst_no_rvalid", {7'd0, rv_seen}, 64'd0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); vga_req = 1'b1; io_req = 1'b1; vga_adr = 16'h0030; io_adr = 16'h0031; io_we = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_first", {vga_gnt, io_gnt}, 2'b10);
      @(negedge clk); vga_req = 1'b0; io_req = 1'b0;
      repeat (3) @(posedge clk);

      // Mixed back-to-back traffic with reads after writes
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cpu_req   = (i % 3) == 0;
         cpu_we    = (i % 9) == 3;
         cpu_adr   = 16'h0040 + 16'(i % 4);
         cpu_wdata = 16'h1000 + 16'(i);
         vga_req   = (i % 4) != 1;
         vga_adr   = 16'h0040 + 16'(i % 3);
         io_req    = (i % 5) != 2;
         io_we     = (i % 2) == 1;
         io_adr    = 16'h0040 + 16'(i % 4);
         io_wdata  = 16'h2000 + 16'(i);
      end
      @(negedge clk); cpu_req = 1'b0; vga_req = 1'b0; io_req = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
